// File: rtl/wgt_shift_bank.sv
// wgt_shift_bank: per-channel weight shift chains with optional double buffering (WGT_SHIFT_BANK_DBL_EN)
module wgt_shift_bank #(
  parameter int DATA_W = 8,
  parameter int TAPS = 3,
  parameter int CH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W*CH-1:0]     in_data,
  input  logic                     swap,
  output logic                     load_done,
  output logic [DATA_W*TAPS*CH-1:0] wgt_out,
  output logic                     act_valid
);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] ld [CH][TAPS];
  logic accept, commit;
  assign in_ready = !stall && state == FILL;
  assign accept = in_valid && in_ready;
  assign commit = !stall && swap && state == FULL;
  assign load_done = state == FULL;
  // fill counter and FILL/FULL state; a swap in FULL restarts the load
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      state <= FILL;
    end else if (commit) begin
      cnt <= '0;
      state <= FILL;
    end else if (accept) begin
      cnt <= cnt + CW'(1);
      state <= cnt == CW'(TAPS - 1) ? FULL : FILL;
    end
  end
  // load bank: each accepted beat pushes one weight into tap 0 of every channel
  always_ff @(posedge clk) begin
    if (rst) ld <= '{default: '0};
    else if (accept)
      for (int c = 0; c < CH; c++) begin
        ld[c][0] <= in_data[c*DATA_W +: DATA_W];
        for (int k = 1; k < TAPS; k++) ld[c][k] <= ld[c][k-1];
      end
  end
`ifdef WGT_SHIFT_BANK_DBL_EN
  logic [DATA_W-1:0] act [CH][TAPS];
  // active bank only changes on a committed swap so loading never disturbs wgt_out
  always_ff @(posedge clk) begin
    if (rst) begin
      act <= '{default: '0};
      act_valid <= 1'b0;
    end else if (commit) begin
      act <= ld;
      act_valid <= 1'b1;
    end
  end
  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
      assign wgt_out[(c*TAPS+k)*DATA_W +: DATA_W] = act[c][k];
    end
  end
`else
  assign act_valid = state == FULL;
  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
      assign wgt_out[(c*TAPS+k)*DATA_W +: DATA_W] = ld[c][k];
    end
  end
`endif
endmodule

// File: tb/tb_wgt_shift_bank.sv
// tb_wgt_shift_bank: directed table-driven checks of wgt_shift_bank (TAPS=3, CH=4, DATA_W=8)
module tb_wgt_shift_bank;
  logic clk = 1'b0;
  logic rst = 1'b0, stall = 1'b0, in_valid = 1'b0, swap = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, load_done, act_valid;
  logic [95:0] wgt_out;
  int checks = 0, errors = 0;

  wgt_shift_bank #(.DATA_W(8), .TAPS(3), .CH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .swap(swap), .load_done(load_done), .wgt_out(wgt_out),
    .act_valid(act_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, s, v, w;
    logic [7:0] d0, d1;
    logic rdy, done, av;
    logic [23:0] w0;
    logic [7:0] w1;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int idx, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, s, v, w, input logic [7:0] d0, d1,
                     input logic rdy, done, av, input logic [23:0] w0, input logic [7:0] w1);
    vec_t t;
    t.r = r; t.s = s; t.v = v; t.w = w; t.d0 = d0; t.d1 = d1;
    t.rdy = rdy; t.done = done; t.av = av; t.w0 = w0; t.w1 = w1;
    tbl.push_back(t);
  endtask

  task automatic step(input logic r, s, v, w, input logic [31:0] d);
    rst = r; stall = s; in_valid = v; swap = w; in_data = d;
    @(posedge clk);
    #1;
    rst = 0; stall = 0; in_valid = 0; swap = 0;
    #1;
  endtask

  initial begin
    logic [95:0] exp_w;
    //   r  s  v  w  d0     d1     rdy done av  ch0 {t2,t1,t0}  ch1 t0
`ifdef WGT_SHIFT_BANK_DBL_EN
    add(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 24'h000000, 8'h00);
    add(0, 0, 1, 0, 8'h01, 8'h00, 1, 0, 0, 24'h000000, 8'h00);
    add(0, 0, 1, 0, 8'h02, 8'h00, 1, 0, 0, 24'h000000, 8'h00);
    add(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 24'h000000, 8'h00);
    add(0, 0, 1, 0, 8'h03, 8'h80, 0, 1, 0, 24'h000000, 8'h00);
    add(0, 0, 1, 0, 8'h09, 8'h11, 0, 1, 0, 24'h000000, 8'h00);
    add(0, 1, 0, 1, 8'h00, 8'h00, 0, 1, 0, 24'h000000, 8'h00);
    add(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 1, 24'h010203, 8'h80);
    add(0, 0, 1, 0, 8'h04, 8'h00, 1, 0, 1, 24'h010203, 8'h80);
    add(0, 1, 1, 0, 8'h07, 8'h00, 1, 0, 1, 24'h010203, 8'h80);
    add(0, 1, 1, 1, 8'h07, 8'h00, 1, 0, 1, 24'h010203, 8'h80);
    add(0, 0, 1, 0, 8'h05, 8'h00, 1, 0, 1, 24'h010203, 8'h80);
    add(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 1, 24'h010203, 8'h80);
    add(0, 0, 1, 0, 8'h06, 8'h00, 0, 1, 1, 24'h010203, 8'h80);
    add(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 1, 24'h040506, 8'h00);
    add(0, 0, 1, 0, 8'h08, 8'h00, 1, 0, 1, 24'h040506, 8'h00);
    add(0, 0, 1, 0, 8'h09, 8'h00, 1, 0, 1, 24'h040506, 8'h00);
    add(1, 1, 1, 1, 8'h0a, 8'h00, 1, 0, 0, 24'h000000, 8'h00);
    add(0, 0, 1, 0, 8'h0b, 8'h00, 1, 0, 0, 24'h000000, 8'h00);
`else
    add(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 24'h000000, 8'h00);
    add(0, 0, 1, 0, 8'h01, 8'h00, 1, 0, 0, 24'h000001, 8'h00);
    add(0, 0, 1, 0, 8'h02, 8'h00, 1, 0, 0, 24'h000102, 8'h00);
    add(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 24'h000102, 8'h00);
    add(0, 0, 1, 0, 8'h03, 8'h80, 0, 1, 1, 24'h010203, 8'h80);
    add(0, 0, 1, 0, 8'h09, 8'h11, 0, 1, 1, 24'h010203, 8'h80);
    add(0, 1, 0, 1, 8'h00, 8'h00, 0, 1, 1, 24'h010203, 8'h80);
    add(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 24'h010203, 8'h80);
    add(0, 0, 1, 0, 8'h04, 8'h00, 1, 0, 0, 24'h020304, 8'h00);
    add(0, 1, 1, 0, 8'h07, 8'h00, 1, 0, 0, 24'h020304, 8'h00);
    add(0, 1, 1, 1, 8'h07, 8'h00, 1, 0, 0, 24'h020304, 8'h00);
    add(0, 0, 1, 0, 8'h05, 8'h00, 1, 0, 0, 24'h030405, 8'h00);
    add(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 24'h030405, 8'h00);
    add(0, 0, 1, 0, 8'h06, 8'h00, 0, 1, 1, 24'h040506, 8'h00);
    add(0, 0, 1, 1, 8'h08, 8'h00, 1, 0, 0, 24'h040506, 8'h00);
    add(0, 0, 1, 0, 8'h08, 8'h00, 1, 0, 0, 24'h050608, 8'h00);
    add(0, 0, 1, 0, 8'h09, 8'h00, 1, 0, 0, 24'h060809, 8'h00);
    add(1, 1, 1, 1, 8'h0a, 8'h00, 1, 0, 0, 24'h000000, 8'h00);
    add(0, 0, 1, 0, 8'h0b, 8'h00, 1, 0, 0, 24'h00000b, 8'h00);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].w, {16'h0, tbl[i].d1, tbl[i].d0});
      chk("in_ready", i, 96'(in_ready), 96'(tbl[i].rdy));
      chk("load_done", i, 96'(load_done), 96'(tbl[i].done));
      chk("act_valid", i, 96'(act_valid), 96'(tbl[i].av));
      chk("ch0_taps", i, 96'(wgt_out[23:0]), 96'(tbl[i].w0));
      chk("ch1_tap0", i, 96'(wgt_out[31:24]), 96'(tbl[i].w1));
    end
    // full-width placement: beat b, channel c carries {c+0xA, b}
    step(1, 0, 0, 0, '0);
    chk("full_reset", 100, wgt_out, 96'h0);
    for (int b = 1; b <= 3; b++) begin
      logic [31:0] d;
      for (int c = 0; c < 4; c++) d[c*8 +: 8] = {4'(c + 10), 4'(b)};
      step(0, 0, 1, 0, d);
    end
`ifdef WGT_SHIFT_BANK_DBL_EN
    chk("full_pre_swap", 101, wgt_out, 96'h0);
    step(0, 0, 0, 1, '0);
`endif
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 3; k++) exp_w[(c*3+k)*8 +: 8] = {4'(c + 10), 4'(3 - k)};
    chk("full_layout", 102, wgt_out, exp_w);
    chk("full_av", 103, 96'(act_valid), 96'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wgt_shift_bank.md
WGT_SHIFT_BANK -- requirements
Module: wgt_shift_bank

Interface
REQ-001 SHALL have parameter DATA_W, 8, signed weight width in bits.
REQ-002 SHALL have parameter TAPS, 3, weights held per channel (kernel row length), TAPS >= 2.
REQ-003 SHALL have parameter CH, 4, independent weight channels loaded in parallel.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port stall  input  1  global freeze, high = hold all state.
REQ-007 SHALL have port in_valid  input  1  in_data beat offered.
REQ-008 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-009 SHALL have port in_data  input  DATA_W*CH  one signed weight per channel, ch c at bits [c*DATA_W +: DATA_W].
REQ-010 SHALL have port swap  input  1  request to commit loaded weights to the active bank.
REQ-011 SHALL have port load_done  output  1  load bank holds TAPS beats.
REQ-012 SHALL have port wgt_out  output  DATA_W*TAPS*CH  active weights, ch c tap k at bits [(c*TAPS+k)*DATA_W +: DATA_W].
REQ-013 SHALL have port act_valid  output  1  wgt_out holds a complete weight set.

Function
REQ-014 SHALL keep a load bank of CH shift chains, each TAPS deep, plus a fill counter 0..TAPS.
REQ-015 SHALL, on accepted beat, per channel shift tap k <= tap k-1 (k>=1), tap 0 <= in_data channel, fill counter +1.
REQ-016 SHALL run a two-state FSM: FILL (counter < TAPS) and FULL (counter == TAPS).
REQ-017 SHALL drive in_ready = !stall & (state == FILL), combinationally.
REQ-018 SHALL drive load_done = (state == FULL), registered.
REQ-019 SHALL, in FULL with swap=1 and stall=0, copy load bank to active bank in one cycle, set act_valid=1, clear counter, return to FILL; wgt_out shows new set the cycle after the swap edge.
REQ-020 SHALL ignore swap in FILL state (no bank copy, counter, or act_valid change).
REQ-021 SHALL hold active bank and act_valid constant during any load; wgt_out changes only on a swap.
REQ-022 SHALL, when stall=1, hold every register unchanged and ignore in_valid and swap.
REQ-023 SHALL treat weights as opaque DATA_W-bit values; no arithmetic, sign preserved bit-exact.
REQ-024 SHALL not accept an in_valid beat in FULL; in_data is not captured until after the swap.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear all load and active taps to 0, counter to 0, state to FILL, act_valid=0, load_done=0.
REQ-026 SHALL give rst priority over stall, swap and in_valid; a partial load aborted by reset is discarded.

Configuration
REQ-027 SHALL support macro WGT_SHIFT_BANK_DBL_EN.
REQ-028 SHALL, with WGT_SHIFT_BANK_DBL_EN defined, implement separate load and active banks as in REQ-014..024 (load next set while current set is in use).
REQ-029 SHALL, without WGT_SHIFT_BANK_DBL_EN, use a single bank: beats shift directly into the taps driving wgt_out; act_valid = load_done = (state == FULL); swap in FULL clears counter and act_valid (restart load) without moving data.

Verification
REQ-030 SHALL pass: reset, then 3 beats ch0 = 1,2,3 (DBL, TAPS=3) -> load_done=1, in_ready=0, act_valid=0, wgt_out all 0.
REQ-031 SHALL pass: after REQ-030 pulse swap -> next cycle ch0 tap0=3, tap1=2, tap2=1, act_valid=1, load_done=0, in_ready=1.
REQ-032 SHALL pass: load 4,5,6 while active=3,2,1, stall=1 for 2 cycles mid-load -> wgt_out stays 3,2,1; counter unchanged during stall; swap gives 6,5,4.
REQ-033 SHALL pass: swap pulsed with counter=1 -> ignored; wgt_out, act_valid, counter unchanged.
REQ-034 SHALL pass: in_data ch1 = -128 (0x80) loaded and swapped -> ch1 tap0 reads 0x80 exactly.
REQ-035 SHALL pass: rst=1 with counter=2 and act_valid=1 -> next cycle all taps 0, act_valid=0, in_ready=1.
